// File: rtl/multdiv_pkg.sv
// ============================================================================
// Module   : multdiv_pkg
// Brief    : Shared constants, state encoding and helpers for multdiv.
// Revision : 1.0
// ============================================================================
`default_nettype none

package multdiv_pkg;

    localparam int MD_WIDTH = 32;
    localparam int MD_ITER  = 32;
    localparam int MD_CNT_W = 6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MULT = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } md_state_t;

    // Magnitude of a two's complement word; -2^31 maps to 0x80000000 unsigned.
    function automatic logic [MD_WIDTH-1:0] md_abs(input logic [MD_WIDTH-1:0] v);
        return v[MD_WIDTH-1] ? (~v + 1'b1) : v;
    endfunction

endpackage

`default_nettype wire

// File: rtl/multdiv_counter.sv
// ============================================================================
// Module   : multdiv_counter
// Brief    : Iteration counter with synchronous clear and an end-of-run flag.
// Revision : 1.0
// ============================================================================
`default_nettype none

module multdiv_counter
    import multdiv_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic last
);

    logic [MD_CNT_W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

    // High on the iteration whose increment brings the count to MD_ITER.
    assign last = en && (count == MD_CNT_W'(MD_ITER - 1));

endmodule

`default_nettype wire

// File: rtl/multdiv.sv
// ============================================================================
// Module   : multdiv
// Brief    : Iterative signed 32-bit Booth multiply / restoring divide unit.
// Revision : 1.0
// ============================================================================
`default_nettype none

module multdiv
    import multdiv_pkg::*;
(
    input  logic                clock,
    input  logic                reset,
    input  logic [MD_WIDTH-1:0] operandA,
    input  logic [MD_WIDTH-1:0] operandB,
    input  logic                ctrlMult,
    input  logic                ctrlDiv,
    input  logic [4:0]          rdIn,
    output logic [MD_WIDTH-1:0] result,
    output logic                exception,
    output logic                resultRdy,
    output logic [4:0]          rdOut,
    output logic                busy
);

    md_state_t state, state_nxt;

    logic [MD_WIDTH-1:0] hi, lo, addend;
    logic                guard, neg_q;
    logic [MD_WIDTH-1:0] hi_nxt, lo_nxt;
    logic                guard_nxt;
    logic [MD_WIDTH:0]   add_a, add_b, sum;
    logic                add_sub;
    logic [MD_WIDTH-1:0] fin_result;
    logic                fin_exc;
    logic                start_mult, start_div, div_zero, div_go;
    logic                iterating, cnt_last;

    assign iterating  = (state == ST_MULT) || (state == ST_DIV);
    assign start_mult = (state == ST_IDLE) && ctrlMult;
    assign start_div  = (state == ST_IDLE) && ctrlDiv && !ctrlMult;
    assign div_zero   = start_div && (operandB == '0);
    assign div_go     = start_div && (operandB != '0);
    assign busy       = ((state == ST_IDLE) && (ctrlMult || ctrlDiv)) || iterating;

    multdiv_counter u_counter (
        .clk  (clock),
        .rst  (reset),
        .clr  (start_mult || start_div),
        .en   (iterating),
        .last (cnt_last)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (ctrlMult) begin
                    state_nxt = ST_MULT;
                end else if (ctrlDiv) begin
                    state_nxt = (operandB == '0) ? ST_DONE : ST_DIV;
                end
            end
            ST_MULT, ST_DIV: begin
                if (cnt_last) begin
                    state_nxt = ST_DONE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Shared 33-bit adder: Booth add/sub of the multiplicand into hi, or the
    // restoring trial subtract of the divisor magnitude from {rem, next bit}.
    always_comb begin
        add_a   = '0;
        add_b   = '0;
        add_sub = 1'b0;
        if (state == ST_MULT) begin
            add_a = {hi[MD_WIDTH-1], hi};
            case ({lo[0], guard})
                2'b01:   add_b = {addend[MD_WIDTH-1], addend};
                2'b10: begin
                    add_b   = {addend[MD_WIDTH-1], addend};
                    add_sub = 1'b1;
                end
                default: add_b = '0;
            endcase
        end else if (state == ST_DIV) begin
            add_a   = {hi, lo[MD_WIDTH-1]};
            add_b   = {1'b0, addend};
            add_sub = 1'b1;
        end
        sum = add_sub ? (add_a - add_b) : (add_a + add_b);
    end

    always_comb begin
        hi_nxt     = hi;
        lo_nxt     = lo;
        guard_nxt  = guard;
        fin_result = '0;
        fin_exc    = 1'b0;
        if (state == ST_MULT) begin
            hi_nxt     = sum[MD_WIDTH:1];
            lo_nxt     = {sum[0], lo[MD_WIDTH-1:1]};
            guard_nxt  = lo[0];
            fin_result = lo_nxt;
            fin_exc    = (hi_nxt != {MD_WIDTH{lo_nxt[MD_WIDTH-1]}});
        end else if (state == ST_DIV) begin
            // A set sign bit means the trial went negative: restore.
            if (!sum[MD_WIDTH]) begin
                hi_nxt = sum[MD_WIDTH-1:0];
                lo_nxt = {lo[MD_WIDTH-2:0], 1'b1};
            end else begin
                hi_nxt = add_a[MD_WIDTH-1:0];
                lo_nxt = {lo[MD_WIDTH-2:0], 1'b0};
            end
            fin_result = neg_q ? (~lo_nxt + 1'b1) : lo_nxt;
            // Only -2^31 / -1 yields a positive quotient with bit 31 set.
            fin_exc    = !neg_q && lo_nxt[MD_WIDTH-1];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hi        <= '0;
            lo        <= '0;
            guard     <= 1'b0;
            addend    <= '0;
            neg_q     <= 1'b0;
            result    <= '0;
            exception <= 1'b0;
            resultRdy <= 1'b0;
            rdOut     <= '0;
        end else begin
            resultRdy <= 1'b0;
            if (start_mult) begin
                hi     <= '0;
                lo     <= operandB;
                guard  <= 1'b0;
                addend <= operandA;
                rdOut  <= rdIn;
            end else if (div_zero) begin
                result    <= '0;
                exception <= 1'b1;
                resultRdy <= 1'b1;
                rdOut     <= rdIn;
            end else if (div_go) begin
                hi     <= '0;
                lo     <= md_abs(operandA);
                addend <= md_abs(operandB);
                neg_q  <= operandA[MD_WIDTH-1] ^ operandB[MD_WIDTH-1];
                rdOut  <= rdIn;
            end else if (iterating) begin
                hi    <= hi_nxt;
                lo    <= lo_nxt;
                guard <= guard_nxt;
                if (cnt_last) begin
                    result    <= fin_result;
                    exception <= fin_exc;
                    resultRdy <= 1'b1;
                end
            end
        end
    end

endmodule

`default_nettype wire
